id_stage_hazard: RTL
====================

// Module: id_stage_hazard
// PURPOSE
//  Parametrised decode stage for the 5-stage pipeline: opcode decode, register file (2R/1W), SVPC target
//  adder and ID/EX pipeline register in one block. Adds over the previous decode stage: synchronous reset,
//  in-stage write-back bypass, load-use stall detection, and flush/bubble insertion.
//  Sits between the IF/IF-ID stage and EX.
// PARAMETERS
//  DATA_W     32  datapath, PC and register width
//  REG_AW     6   register address width; the file holds 2**REG_AW registers, none hardwired to zero
//  BYPASS_EN  1   1: a same-cycle write-back is visible to the reads
//  HAZARD_EN  1   1: the load-use stall is generated; 0: stall is tied to 0
// PORTS
//  clk        in   1        clock; all state updates on the rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        in_instr/in_pc are valid
//  in_pc      in   DATA_W   PC of the instruction being decoded
//  in_instr   in   32       op[31:28] rd[27:22] rs[21:16] rt[15:10] imm[21:0]
//  flush      in   1        squash the instruction in ID (taken branch or jump from a later stage)
//  wb_en      in   1        register write enable from WB
//  wb_rd      in   REG_AW   write-back destination register
//  wb_data    in   DATA_W   write-back data
//  stall      out  1        combinational; IF must hold its PC and IF/ID register
//  out_valid  out  1        ID/EX holds a real instruction
//  out_pc     out  DATA_W   in_pc, or in_pc + sext(imm) for SVPC
//  out_imm    out  DATA_W   sign-extended imm[21:0]
//  out_rd     out  REG_AW   destination register
//  out_rd1    out  DATA_W   R[rs] after bypass
//  out_rd2    out  DATA_W   R[rt] after bypass
//  out_brz, out_brn, out_j, out_regw, out_memw, out_memr, out_alusrc   out 1    registered control bits
//  out_aluop  out  3        ALU operation
// BEHAVIOUR
//  Opcodes: NOP 0000, SVPC 1111, LD 1110, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111,
//  J 1000, BRZ 1001, JM 1010, BRN 1011. Any other opcode decodes as NOP (all control bits 0).
//  Reads rs: LD ST ADD INC NEG SUB J BRZ JM BRN. Reads rt: ST ADD SUB.
//  Latency: one cycle. ID/EX loads on each clk edge from the current in_* and the register-file reads.
//  Register file: reads are combinational, the write is synchronous on wb_en.
//  - BYPASS_EN=1: if wb_en and wb_rd==rs (or rt), the read returns wb_data in that same cycle.
//  - BYPASS_EN=0: the read returns the old register value.
//  Load-use stall: stall = HAZARD_EN & in_valid & out_valid & out_memr & !flush
//  & ((reads_rs & out_rd==rs) | (reads_rt & out_rd==rt)).
//  Each edge, exactly one of the following applies, highest priority first:
//   1. rst: all out_* <= 0, out_valid <= 0, all registers <= 0; stall is 0 while rst is high.
//   2. flush: bubble into ID/EX. A flush in the same cycle as a stall condition wins; no stall is raised.
//   3. stall: bubble into ID/EX. IF/IF-ID hold, so the stalled instruction is presented again next
//      cycle and proceeds once the load has left ID/EX. The stall lasts exactly 1 cycle per load-use pair.
//   4. !in_valid: bubble.
//   5. otherwise: load the decoded instruction and set out_valid <= 1.
//  Bubble: out_valid and every control bit are 0; every data output is 0.
//  The register-file write is independent of flush/stall and always completes when wb_en=1 (except rst).
//  SVPC adder: DATA_W-bit add, wraps modulo 2**DATA_W.
//  The imm field overlaps rs/rt; decode uses whichever fields the opcode defines.
//  A reset asserted mid-operation discards the ID/EX contents. A write-back in the reset cycle is dropped.
// STRUCTURE
//  Package id_pkg: opcode localparams, aluop encodings, a ctrl_t bundle of the control bits,
//  and functions decode_ctrl(op), reads_rs(op), reads_rt(op).
//  Sub-module id_regfile: parametrised by DATA_W, REG_AW, BYPASS_EN; ports clk, rst, 2 read ports, 1 write port.
//  Hazard logic, SVPC adder and the ID/EX register stay in id_stage_hazard.
// TESTING
//  1. rst high for 2 cycles while in_valid=1 with ADD -> all out_*=0 and stall=0; after release, R[0..63] read 0.
//  2. wb_en=1, wb_rd=5, wb_data=0x1234 in the same cycle as ADD rd=1 rs=5 rt=5 -> next cycle
//     out_rd1=out_rd2=0x1234 with BYPASS_EN=1; with BYPASS_EN=0 both read the old value (0).
//  3. LD rd=7 followed by SUB rs=7 -> stall=1 for exactly 1 cycle with a bubble in ID/EX;
//     SUB then issues with out_aluop=SUB and out_regw=1.
//     Same sequence with SUB rs=8 rt=9 -> stall never asserted.
//  4. SVPC rd=3 imm=-4 (0x3FFFFC) at in_pc=0x100 -> out_pc=0xFC and out_imm=0xFFFFFFFC.
//     in_pc=0xFFFFFFFE with imm=+4 -> out_pc=0x2 (wrap).
//  5. flush=1 together with a load-use condition -> stall=0; next cycle out_valid=0 and out_memw=out_regw=0.
//  6. Random opcode stream vs. a reference decode model -> every registered control bit matches the table.
//     Opcodes 0001/0010/1100/1101 -> all control bits 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU encodings, the
// control-bit bundle and the per-opcode decode/operand-use functions.
package id_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_INC  = 3'd2;
    localparam logic [2:0] ALU_NEG  = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;

    typedef struct packed {
        logic       brz;
        logic       brn;
        logic       j;
        logic       regw;
        logic       memw;
        logic       memr;
        logic       alusrc;
        logic [2:0] aluop;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_SVPC: begin c.regw = 1'b1; c.aluop = ALU_PASS; end
            OP_LD:   begin c.regw = 1'b1; c.memr = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_ADD; end
            OP_ST:   begin c.memw = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_ADD; end
            OP_ADD:  begin c.regw = 1'b1; c.aluop = ALU_ADD; end
            OP_INC:  begin c.regw = 1'b1; c.aluop = ALU_INC; end
            OP_NEG:  begin c.regw = 1'b1; c.aluop = ALU_NEG; end
            OP_SUB:  begin c.regw = 1'b1; c.aluop = ALU_SUB; end
            OP_J:    begin c.j = 1'b1; c.aluop = ALU_PASS; end
            OP_BRZ:  begin c.brz = 1'b1; c.aluop = ALU_PASS; end
            // JM fetches its target from memory, so it counts as a load for hazards.
            OP_JM:   begin c.j = 1'b1; c.memr = 1'b1; c.aluop = ALU_PASS; end
            OP_BRN:  begin c.brn = 1'b1; c.aluop = ALU_PASS; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic reads_rs(input logic [3:0] op);
        case (op)
            OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
            OP_J, OP_BRZ, OP_JM, OP_BRN: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rt(input logic [3:0] op);
        case (op)
            OP_ST, OP_ADD, OP_SUB: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 2-read / 1-write register file with combinational reads, synchronous write
// and an optional same-cycle write-back bypass onto both read ports.
module id_regfile #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 6,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // NOTE: combinational blocks use blocking '=' and assign a full default first,
    // so every path drives every bit and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[wa] = wd;
    end

    // NOTE: the array is cleared by reset because software expects all registers
    // to read zero afterwards; this forbids mapping the file onto a reset-less RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        if (BYPASS_EN && we && (wa == ra1)) rd1 = wd;
        if (BYPASS_EN && we && (wa == ra2)) rd2 = wd;
    end

endmodule

// File: rtl/id_stage_hazard.sv
// Decode stage: opcode decode, register-file read, SVPC target add, load-use
// stall detection and the ID/EX pipeline register with flush/bubble insertion.
module id_stage_hazard
    import id_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 6,
    parameter bit BYPASS_EN = 1'b1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic              out_brz,
    output logic              out_brn,
    output logic              out_j,
    output logic              out_regw,
    output logic              out_memw,
    output logic              out_memr,
    output logic              out_alusrc,
    output logic [2:0]        out_aluop
);

    localparam int IMM_W = 22;

    logic [3:0]        op;
    logic [REG_AW-1:0] rd_f, rs_f, rt_f;
    logic [DATA_W-1:0] imm_sext, rf_rd1, rf_rd2;
    logic              hazard;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d, imm_q, imm_d, rd1_q, rd1_d, rd2_q, rd2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    ctrl_t             ctrl_q, ctrl_d;

    // The immediate overlaps rs/rt; each opcode only uses the fields it defines.
    assign op       = in_instr[31:28];
    assign rd_f     = in_instr[22 +: REG_AW];
    assign rs_f     = in_instr[16 +: REG_AW];
    assign rt_f     = in_instr[10 +: REG_AW];
    assign imm_sext = {{(DATA_W - IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};

    id_regfile #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .BYPASS_EN (BYPASS_EN)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs_f),
        .ra2 (rt_f),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (wb_en),
        .wa  (wb_rd),
        .wd  (wb_data)
    );

    assign hazard = in_valid & valid_q & ctrl_q.memr
                  & ((reads_rs(op) & (rd_q == rs_f)) | (reads_rt(op) & (rd_q == rt_f)));
    // A flush squashes the consumer anyway, so it suppresses the stall.
    assign stall  = HAZARD_EN & ~rst & ~flush & hazard;

    always_comb begin
        valid_d = 1'b0;
        pc_d    = '0;
        imm_d   = '0;
        rd_d    = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        ctrl_d  = '0;
        if (!flush && !stall && in_valid) begin
            valid_d = 1'b1;
            pc_d    = (op == OP_SVPC) ? in_pc + imm_sext : in_pc;
            imm_d   = imm_sext;
            rd_d    = rd_f;
            rd1_d   = rf_rd1;
            rd2_d   = rf_rd2;
            ctrl_d  = decode_ctrl(op);
        end
    end

    // NOTE: sequential state is updated only with non-blocking '<=' so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_pc     = pc_q;
    assign out_imm    = imm_q;
    assign out_rd     = rd_q;
    assign out_rd1    = rd1_q;
    assign out_rd2    = rd2_q;
    assign out_brz    = ctrl_q.brz;
    assign out_brn    = ctrl_q.brn;
    assign out_j      = ctrl_q.j;
    assign out_regw   = ctrl_q.regw;
    assign out_memw   = ctrl_q.memw;
    assign out_memr   = ctrl_q.memr;
    assign out_alusrc = ctrl_q.alusrc;
    assign out_aluop  = ctrl_q.aluop;

endmodule
